// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding data memory behind a load/store
// wrapper. One request is accepted in IDLE, waits Latency cycles, then answers
// with a one-cycle data_valid pulse. Byte-masked stores, full-word loads.
// Optional feature macro: MEM_RANGE_CHECK_EN (out-of-range word index flags
// mem_err and suppresses the access; otherwise the index wraps modulo Depth).
module data_mem_responder #(
  parameter int DataWidth = 32,
  parameter int Depth     = 256,
  parameter int Latency   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_req,
  input  logic                 mem_we,
  input  logic [31:0]          mem_addr,
  input  logic [3:0]           mem_mask,
  input  logic [DataWidth-1:0] mem_wdata,
  output logic                 mem_ready,
  output logic                 data_valid,
  output logic [DataWidth-1:0] mem_rdata,
  output logic                 mem_err
);

  localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                 state, state_nxt;
  logic [3:0]             cnt, cnt_nxt;
  logic                   enter_resp;

  logic                   we_q;
  logic [29:0]            idx_q;
  logic [3:0]             mask_q;
  logic [DataWidth-1:0]   wdata_q;

  logic                   cur_we;
  logic [29:0]            cur_idx;
  logic [3:0]             cur_mask;
  logic [DataWidth-1:0]   cur_wdata;
  logic [DataWidth-1:0]   ben;
  logic [AW-1:0]          widx;
  logic                   commit_ok;

  logic [DataWidth-1:0]   mem [Depth];
  logic [DataWidth-1:0]   rdata_q;

  // Byte offset bits never select anything: accesses are whole words.
  logic                   unused_addr_lsb;
  assign unused_addr_lsb = ^mem_addr[1:0];

  assign mem_ready  = (state == IDLE);
  assign data_valid = (state == RESP);
  assign mem_rdata  = rdata_q;

  // With Latency=1 the RESP-entry edge is also the accept edge, so the access
  // must use the live request; otherwise it uses the registered copy.
  assign cur_we    = (state == IDLE) ? mem_we         : we_q;
  assign cur_idx   = (state == IDLE) ? mem_addr[31:2] : idx_q;
  assign cur_mask  = (state == IDLE) ? mem_mask       : mask_q;
  assign cur_wdata = (state == IDLE) ? mem_wdata      : wdata_q;

  // Bit enables expanded from the 4 byte lanes; bytes beyond lane 3 never write.
  for (genvar i = 0; i < DataWidth; i++) begin : g_ben
    if (i / 8 < 4) begin : g_lane
      assign ben[i] = cur_mask[i/8];
    end else begin : g_none
      assign ben[i] = 1'b0;
    end
  end

`ifdef MEM_RANGE_CHECK_EN
  logic err_q;
  assign commit_ok = ({2'b00, cur_idx} < 32'(Depth));
  assign widx      = AW'(cur_idx);
  assign mem_err   = data_valid & err_q;
`else
  assign commit_ok = 1'b1;
  assign widx      = AW'(cur_idx % 30'(Depth));
  assign mem_err   = 1'b0;
`endif

  // State and latency counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: IDLE -> WAIT (count down) -> RESP -> IDLE; WAIT skipped at Latency=1.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    case (state)
      IDLE: if (mem_req) begin
        if (Latency == 1) begin
          state_nxt  = RESP;
          cnt_nxt    = 4'd0;
          enter_resp = 1'b1;
        end else begin
          state_nxt = WAIT;
          cnt_nxt   = 4'(Latency - 1);
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the request on the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      idx_q   <= '0;
      mask_q  <= 4'd0;
      wdata_q <= '0;
    end else if (state == IDLE && mem_req) begin
      we_q    <= mem_we;
      idx_q   <= mem_addr[31:2];
      mask_q  <= mem_mask;
      wdata_q <= mem_wdata;
    end
  end

  // Array write on RESP entry; contents survive reset, but no commit while in reset.
  always_ff @(posedge clk) begin
    if (rst_n && enter_resp && cur_we && commit_ok)
      mem[widx] <= (mem[widx] & ~ben) | (cur_wdata & ben);
  end

  // Load data captured on RESP entry and held until the next load response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (enter_resp && !cur_we) begin
      rdata_q <= commit_ok ? mem[widx] : '0;
    end
  end

`ifdef MEM_RANGE_CHECK_EN
  // Range error latched with the response it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          err_q <= 1'b0;
    else if (enter_resp) err_q <= !commit_ok;
  end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized scoreboard bench for data_mem_responder (Latency=2, Depth=256).
// A driver issues requests and pushes expected responses from a word-array
// model; a monitor pops and compares on every data_valid pulse.
module tb_data_mem_responder;
  localparam int DW  = 32;
  localparam int DEP = 256;
  localparam int LAT = 2;

  logic          clk, rst_n;
  logic          mem_req, mem_we;
  logic [31:0]   mem_addr;
  logic [3:0]    mem_mask;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready, data_valid, mem_err;
  logic [DW-1:0] mem_rdata;

  data_mem_responder #(.DataWidth(DW), .Depth(DEP), .Latency(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_mask(mem_mask), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .data_valid(data_valid), .mem_rdata(mem_rdata),
    .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [DEP];
  logic [31:0] last_rdata = 32'd0;
  int unsigned last_acc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour: word array indexed by addr/4, byte-lane merge on stores.
  task automatic model(input logic we, input logic [31:0] addr, input logic [3:0] mask,
                       input logic [31:0] wdata, output logic [31:0] er, output logic ee);
    int unsigned w;
    bit inr;
    w = addr >> 2;
`ifdef MEM_RANGE_CHECK_EN
    inr = (w < DEP);
`else
    inr = 1'b1;
    w   = w % DEP;
`endif
    if (we) begin
      if (inr)
        for (int b = 0; b < 4; b++)
          if (mask[b]) mdl[w][8*b +: 8] = wdata[8*b +: 8];
    end else begin
      last_rdata = inr ? mdl[w] : 32'd0;
    end
    er = last_rdata;
    ee = !inr;
  endtask

  // Present a request and hold it until accepted; optionally check back-pressure.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] mask,
                       input logic [31:0] wdata, input bit burst, input bit track);
    int lows = 0;
    exp_t e;
    @(negedge clk);
    mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_mask = mask; mem_wdata = wdata;
    while (!mem_ready && lows < 20) begin
      lows++;
      @(negedge clk);
    end
    if (!mem_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: ready stayed %b, expected 1", mem_ready);
      mem_req = 1'b0;
      return;
    end
    if (burst) begin
      chk("ready_low_cycles", 32'(lows), 32'(LAT));
      chk("accept_spacing", 32'(cyc + 1 - last_acc), 32'(LAT + 1));
    end
    last_acc = cyc + 1;
    if (track) begin
      model(we, addr, mask, wdata, e.rdata, e.err);
      e.cyc = cyc + LAT;
      sb.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    mem_req = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ready", {31'd0, mem_ready}, 32'd1);
    chk("rst_valid", {31'd0, data_valid}, 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_err",   {31'd0, mem_err}, 32'd0);
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (data_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid: got data_valid=1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("resp_cycle", 32'(cyc), 32'(e.cyc));
          chk("rdata", mem_rdata, e.rdata);
          chk("err", {31'd0, mem_err}, {31'd0, e.err});
        end
      end else begin
        chk("err_idle", {31'd0, mem_err}, 32'd0);
      end
    end
  end

  initial begin
    int g;
    bit hold;
    logic [31:0] a;
    rst_n = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
    mem_addr = '0; mem_mask = '0; mem_wdata = '0;

    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Fill the whole array with back-to-back stores (request held high).
    for (int i = 0; i < DEP; i++)
      issue(1'b1, 32'(i * 4), 4'hF, $urandom, i > 0, 1'b1);
    idle();

    // Word round trip, byte-lane merge, empty mask.
    issue(1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 0, 1); idle();
    issue(1'b0, 32'h10, 4'b0000, 32'h0,        0, 1); idle();
    issue(1'b1, 32'h10, 4'b0100, 32'h00AA0000, 0, 1); idle();
    issue(1'b0, 32'h10, 4'b0000, 32'h0,        0, 1); idle();
    issue(1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, 0, 1); idle();
    issue(1'b0, 32'h10, 4'b0000, 32'h0,        0, 1); idle();

    // Range handling: 0x400 is word 256.
    issue(1'b1, 32'h400, 4'b1111, 32'hCAFEF00D, 0, 1); idle();
    issue(1'b0, 32'h0,   4'b0000, 32'h0,        0, 1); idle();
    issue(1'b0, 32'h404, 4'b0000, 32'h0,        0, 1); idle();

    // Reset while a store waits: no commit, no pulse.
    issue(1'b1, 32'h20, 4'b1111, 32'h12345678, 0, 0);
    mem_req = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs();
    last_rdata = 32'd0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 32'h20, 4'b0000, 32'h0, 0, 1); idle();

    // Random traffic with occasional gaps and out-of-range addresses.
    hold = 1'b0;
    for (int n = 0; n < 300; n++) begin
      g = $urandom_range(0, 2);
      if (g != 0 || !hold) begin
        repeat (g) idle();
        hold = 1'b0;
      end
      a = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(256, 1023)) : 32'($urandom_range(0, 255));
      a = (a << 2) | 32'($urandom_range(0, 3));
      issue($urandom_range(0, 1) == 1, a, 4'($urandom), $urandom, hold, 1'b1);
      hold = 1'b1;
    end
    idle();

    // Drain outstanding expectations, bounded.
    for (int t = 0; t < 20 && sb.size() != 0; t++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d responses missing, expected 0", sb.size());
    end
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DataWidth, default 32, data word width.
REQ-002 SHALL have parameter Depth, default 256, number of words in the memory array.
REQ-003 SHALL have parameter Latency, default 2, cycles from request accept to response (legal range 1..8).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port mem_req  input  1  request strobe from the core load/store wrapper.
REQ-007 SHALL have port mem_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port mem_addr  input  32  byte address; word index = mem_addr[31:2].
REQ-009 SHALL have port mem_mask  input  4  byte enables for stores (bit i = byte lane i).
REQ-010 SHALL have port mem_wdata  input  DataWidth  lane-aligned store data.
REQ-011 SHALL have port mem_ready  output  1  high when a request can be accepted.
REQ-012 SHALL have port data_valid  output  1  one-cycle response pulse, for both loads and stores.
REQ-013 SHALL have port mem_rdata  output  DataWidth  full aligned word returned by a load.
REQ-014 SHALL have port mem_err  output  1  address-range error flag, present in every build.

Function
REQ-015 SHALL implement states IDLE, WAIT and RESP; mem_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on a rising edge where mem_req = 1 and mem_ready = 1, registering mem_we, mem_addr, mem_mask and mem_wdata.
REQ-017 SHALL ignore mem_req while not in IDLE; no queuing of requests.
REQ-018 SHALL, on accept, go to WAIT with a down-counter loaded to Latency-1, or straight to RESP when Latency = 1.
REQ-019 SHALL decrement the counter each cycle in WAIT and enter RESP on the edge where the counter equals 1.
REQ-020 SHALL assert data_valid for exactly one cycle in RESP, so data_valid is high in the Latency-th cycle after the accept edge.
REQ-021 SHALL return to IDLE after RESP; maximum throughput is one transaction per Latency+1 cycles.
REQ-022 SHALL commit a store on the edge entering RESP, updating only the byte lanes whose mem_mask bit is 1.
REQ-023 SHALL complete a store with mem_mask = 4'b0000 normally (data_valid pulses) with no array change.
REQ-024 SHALL load mem_rdata on the edge entering RESP with the addressed word, including all earlier committed stores.
REQ-025 SHALL hold mem_rdata until the next load response; stores SHALL NOT change mem_rdata.
REQ-026 SHALL drive mem_err = 0 whenever data_valid = 0.

Reset
REQ-027 SHALL, while rst_n = 0, force state IDLE, counter 0, mem_ready 1, data_valid 0, mem_rdata 0 and mem_err 0, independent of clk.
REQ-028 SHALL abort an in-flight transaction on reset: no store commit and no data_valid pulse.
REQ-029 SHALL NOT clear the memory array on reset.

Configuration
REQ-030 SHALL use macro MEM_RANGE_CHECK_EN to compile address-range checking in or out.
REQ-031 SHALL, with MEM_RANGE_CHECK_EN defined, flag a word index >= Depth: no store commit, load returns mem_rdata = 0, and mem_err = 1 in the same cycle as data_valid.
REQ-032 SHALL, without MEM_RANGE_CHECK_EN, wrap the word index modulo Depth and tie mem_err to 0.

Verification (Latency=2, Depth=256)
REQ-033 SHALL check reset: assert rst_n = 0 mid-cycle -> mem_ready = 1, data_valid = 0, mem_rdata = 0, mem_err = 0 with no clk edge required.
REQ-034 SHALL check word round trip: store 0xDEADBEEF to 0x10 with mask 1111, then load 0x10 -> data_valid 2 cycles after accept and mem_rdata = 0xDEADBEEF.
REQ-035 SHALL check byte lanes: after REQ-034, store 0x00AA0000 to 0x10 with mask 0100, then load 0x10 -> mem_rdata = 0xDEAABEEF.
REQ-036 SHALL check back-pressure: hold mem_req = 1 continuously -> mem_ready low for 2 cycles after each accept and next accept exactly 3 cycles after the previous one.
REQ-037 SHALL check reset mid-store: store 0x12345678 to 0x20, pull rst_n low in WAIT -> no data_valid, and a later load of 0x20 returns the prior contents.
REQ-038 SHALL check range handling: store 0xCAFEF00D to 0x400 -> with macro, mem_err = 1 with data_valid and word 0 is unchanged; without macro, a load of 0x0 returns 0xCAFEF00D.
